// File: rtl/tdm_demux.sv
// Time-division demultiplexer: splits an interleaved byte stream with a start-of-frame
// marker into LANES parallel lanes, publishing each completed frame atomically.
module tdm_demux #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  localparam int SLOT_W = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [DATA_W-1:0]       in_data,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_valid,
  output logic [LANES-1:0]        lane_strobe,
  output logic [SLOT_W-1:0]       slot,
  output logic                    locked,
  output logic                    sync_err
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

  state_t                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [DATA_W-1:0]       stage_q [LANES];
  logic [LANES*DATA_W-1:0] out_data_q;
  logic [LANES*DATA_W-1:0] frame_w;
  logic                    out_valid_q;
  logic                    sync_err_q;
  logic [LANES-1:0]        strobe_q;

  logic                    wr_en;
  logic [SLOT_W-1:0]       wr_idx;
  logic                    publish;
  logic                    err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Any SOF beat seen while accepting is slot 0 of a frame, so the next slot is always 1.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sof) begin
            state_d = RUN;
            slot_d  = SLOT_W'(1);
          end
        end
        RUN: begin
          if (in_sof) begin
            slot_d = SLOT_W'(1);
          end else if (slot_q == '0) begin
            state_d = HUNT;
            slot_d  = '0;
          end else begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    publish = 1'b0;
    err     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: wr_en = in_sof;
        RUN: begin
          if (in_sof) begin
            wr_en = 1'b1;
            err   = (slot_q != '0);
          end else if (slot_q == '0) begin
            err = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = slot_q;
            publish = (slot_q == LAST_SLOT);
          end
        end
        default: ;
      endcase
    end
  end

  // The final slot bypasses staging so the whole frame lands in out_data on one edge.
  always_comb begin
    frame_w = '0;
    for (int i = 0; i < LANES; i++) begin
      frame_w[i*DATA_W +: DATA_W] = (i == LANES - 1) ? in_data : stage_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) stage_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      strobe_q    <= '0;
    end else begin
      if (wr_en) stage_q[wr_idx] <= in_data;
      if (publish) out_data_q <= frame_w;
      out_valid_q <= publish;
      sync_err_q  <= err;
      strobe_q    <= wr_en ? (LANES'(1) << wr_idx) : '0;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign lane_strobe = strobe_q;
  assign slot        = slot_q;
  assign locked      = (state_q == RUN);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed frames plus random traffic, checked by a
// queue-based frame model through a per-cycle scoreboard and a frame scoreboard.
module tb_tdm_demux;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int SLOT_W = $clog2(LANES);
  localparam int OW     = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_sof = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [OW-1:0]     out_data;
  logic              out_valid;
  logic [LANES-1:0]  lane_strobe;
  logic [SLOT_W-1:0] slot;
  logic              locked;
  logic              sync_err;

  always #5 clk = ~clk;

  tdm_demux #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .lane_strobe(lane_strobe),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  typedef struct packed {
    logic              ov;
    logic              err;
    logic [LANES-1:0]  strobe;
    logic [SLOT_W-1:0] slot;
    logic              locked;
    logic [OW-1:0]     data;
  } cyc_t;

  cyc_t          exp_cyc[$];
  logic [OW-1:0] exp_q[$];
  int            tests_run = 0;
  int            tests_failed = 0;

  // Reference model: beats collected so far in the current frame, and hunt flag.
  bit                m_hunt = 1'b1;
  logic [DATA_W-1:0] m_cur[$];
  logic [OW-1:0]     m_out = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [DATA_W-1:0] d);
    cyc_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_sof = s; in_data = d;
    e = '0;
    if (r) begin
      m_hunt = 1'b1;
      m_cur.delete();
      m_out = '0;
    end else if (v) begin
      if (m_hunt) begin
        if (s) begin
          m_cur.delete(); m_cur.push_back(d);
          m_hunt = 1'b0;
          e.strobe = 1;
        end
      end else if (s) begin
        e.err = (m_cur.size() != 0);
        m_cur.delete(); m_cur.push_back(d);
        e.strobe = 1;
      end else if (m_cur.size() == 0) begin
        e.err = 1'b1;
        m_hunt = 1'b1;
      end else begin
        e.strobe = LANES'(1) << m_cur.size();
        m_cur.push_back(d);
        if (m_cur.size() == LANES) begin
          for (int i = 0; i < LANES; i++) m_out[i*DATA_W +: DATA_W] = m_cur[i];
          e.ov = 1'b1;
          exp_q.push_back(m_out);
          m_cur.delete();
        end
      end
    end
    e.slot   = SLOT_W'(m_cur.size());
    e.locked = !m_hunt;
    e.data   = m_out;
    exp_cyc.push_back(e);
  endtask

  task automatic beat(input logic s, input logic [DATA_W-1:0] d);
    step(1'b0, 1'b1, s, d);
  endtask

  always @(posedge clk) begin : monitor
    cyc_t e;
    #1;
    if (exp_cyc.size() > 0) begin
      e = exp_cyc.pop_front();
      check("out_valid",   out_valid,   e.ov);
      check("sync_err",    sync_err,    e.err);
      check("lane_strobe", lane_strobe, e.strobe);
      check("slot",        slot,        e.slot);
      check("locked",      locked,      e.locked);
      check("out_data",    out_data,    e.data);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL frame: unexpected out_valid with data %0h, expected no frame", out_data);
      end else begin
        check("frame", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DATA_W-1:0] b;
    // Reset with random inputs, then non-SOF beats while hunting.
    repeat (2) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    beat(1'b0, 8'hAA);
    beat(1'b0, 8'hBB);
    // Clean frame.
    beat(1'b1, 8'h11); beat(1'b0, 8'h22); beat(1'b0, 8'h33); beat(1'b0, 8'h44);
    // Same frame with idle gaps carrying a stray SOF.
    for (int i = 0; i < LANES; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b1, 8'($urandom));
      b = 8'(8'h11 * (i + 1));
      beat(i == 0, b);
    end
    // Back-to-back frames.
    for (int i = 0; i < 2 * LANES; i++) begin
      b = 8'(8'h11 * (i + 1));
      beat((i % LANES) == 0, b);
    end
    // Early SOF restarts the frame.
    beat(1'b1, 8'h01); beat(1'b0, 8'h02);
    beat(1'b1, 8'h10); beat(1'b0, 8'h20); beat(1'b0, 8'h30); beat(1'b0, 8'h40);
    // Missing SOF, then reset mid-frame, then a clean frame.
    beat(1'b0, 8'h99);
    beat(1'b1, 8'h01); beat(1'b0, 8'h02);
    step(1'b1, 1'b1, 1'b0, 8'h03);
    beat(1'b0, 8'h55);
    beat(1'b1, 8'hA1); beat(1'b0, 8'hA2); beat(1'b0, 8'hA3); beat(1'b0, 8'hA4);
    // Random traffic, mostly well-formed with occasional violations and resets.
    for (int n = 0; n < 600; n++) begin
      logic r, v, s;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (m_cur.size() == 0) s = ($urandom_range(0, 7) != 0);
      else                   s = ($urandom_range(0, 7) == 0);
      step(r, v, s, 8'($urandom));
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    check("cycle_queue_drained", 128'(exp_cyc.size()), 128'd0);
    check("frame_queue_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
